// File: rtl/icache_pkg.sv
// Shared definitions for the instruction-cache refill path: line geometry,
// refill FSM encoding and the line-base helper.
package icache_pkg;

    localparam int LINE_WORDS    = 8;
    localparam int WORD_OFF_BITS = 3;
    localparam int LINE_BYTES    = 32;

    localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;
    localparam logic [31:0] LINE_BASE_MASK = ~(32'(LINE_BYTES) - 32'd1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_RESP   = 3'd2,
        ST_UPDATE = 3'd3,
        ST_DRAIN  = 3'd4
    } refill_state_t;

    function automatic logic [31:0] line_base(input logic [31:0] addr);
        return addr & LINE_BASE_MASK;
    endfunction

endpackage

// File: rtl/icache_line_buf.sv
// Line assembly buffer: one 32-bit register per word, written one beat at a
// time and cleared by reset; contents persist until overwritten.
module icache_line_buf #(
    parameter int LINE_WORDS    = 8,
    parameter int WORD_OFF_BITS = 3
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     wr_en,
    input  logic [WORD_OFF_BITS-1:0] wr_idx,
    input  logic [31:0]              wr_data,
    output logic [31:0]              w0,
    output logic [31:0]              w1,
    output logic [31:0]              w2,
    output logic [31:0]              w3,
    output logic [31:0]              w4,
    output logic [31:0]              w5,
    output logic [31:0]              w6,
    output logic [31:0]              w7
);

    for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_word
        logic [31:0] word_q;
        logic [31:0] word_d;

        always_comb begin
            word_d = word_q;
            if (wr_en && (wr_idx == WORD_OFF_BITS'(gi))) begin
                word_d = wr_data;
            end
        end

        always_ff @(posedge clk) begin
            if (srst) begin
                word_q <= '0;
            end else begin
                word_q <= word_d;
            end
        end
    end

    assign w0 = g_word[0].word_q;
    assign w1 = g_word[1].word_q;
    assign w2 = g_word[2].word_q;
    assign w3 = g_word[3].word_q;
    assign w4 = g_word[4].word_q;
    assign w5 = g_word[5].word_q;
    assign w6 = g_word[6].word_q;
    assign w7 = g_word[7].word_q;

endmodule

// File: rtl/icache_refill.sv
// Instruction-cache line refill engine: fetches the 8-word line holding PC one
// word at a time from memory, then strobes the assembled line into the cache.
module icache_refill
    import icache_pkg::*;
#(
    parameter int LINE_WORDS    = 8,
    parameter int WORD_OFF_BITS = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] PC,
    input  logic        miss,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [31:0] w0,
    output logic [31:0] w1,
    output logic [31:0] w2,
    output logic [31:0] w3,
    output logic [31:0] w4,
    output logic [31:0] w5,
    output logic [31:0] w6,
    output logic [31:0] w7,
    output logic        update,
    output logic        stall,
    output logic [31:0] refill_count
);

    localparam logic [2:0] S_IDLE   = ST_IDLE;
    localparam logic [2:0] S_REQ    = ST_REQ;
    localparam logic [2:0] S_RESP   = ST_RESP;
    localparam logic [2:0] S_UPDATE = ST_UPDATE;
    localparam logic [2:0] S_DRAIN  = ST_DRAIN;

    logic [2:0]               state_q, state_d;
    logic [WORD_OFF_BITS-1:0] beat_q, beat_d;
    logic [31:0]              base_q, base_d;
    logic [31:0]              refill_count_q, refill_count_d;
    logic                     buf_we;
    logic                     last_beat;

    assign last_beat = (beat_q == WORD_OFF_BITS'(LINE_WORDS - 1));

    always_comb begin
        state_d        = state_q;
        beat_d         = beat_q;
        base_d         = base_q;
        refill_count_d = refill_count_q;
        buf_we         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (miss && !flush) begin
                    base_d  = line_base(PC);
                    beat_d  = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (mem_ready) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                // A flush racing the response drops the word; nothing is outstanding after it.
                if (mem_rvalid) begin
                    if (flush) begin
                        state_d = S_IDLE;
                    end else begin
                        buf_we = 1'b1;
                        if (last_beat) begin
                            state_d = S_UPDATE;
                        end else begin
                            beat_d  = beat_q + WORD_OFF_BITS'(1);
                            state_d = S_REQ;
                        end
                    end
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (mem_rvalid) begin
                    state_d = S_IDLE;
                end
            end
            S_UPDATE: begin
                state_d = S_IDLE;
                if (refill_count_q != '1) begin
                    refill_count_d = refill_count_q + 32'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q        <= S_IDLE;
            beat_q         <= '0;
            base_q         <= '0;
            refill_count_q <= '0;
        end else begin
            state_q        <= state_d;
            beat_q         <= beat_d;
            base_q         <= base_d;
            refill_count_q <= refill_count_d;
        end
    end

    // Gating with flush guarantees a redirected request never reaches memory.
    assign mem_req      = (state_q == S_REQ) && !flush;
    assign mem_addr     = (state_q == S_REQ)
                        ? base_q + {{(30 - WORD_OFF_BITS){1'b0}}, beat_q, 2'b00}
                        : 32'd0;
    assign update       = (state_q == S_UPDATE);
    assign stall        = miss || (state_q != S_IDLE);
    assign refill_count = refill_count_q;

    icache_line_buf #(
        .LINE_WORDS   (LINE_WORDS),
        .WORD_OFF_BITS(WORD_OFF_BITS)
    ) u_line_buf (
        .clk    (CLK),
        .srst   (RST),
        .wr_en  (buf_we),
        .wr_idx (beat_q),
        .wr_data(mem_rdata),
        .w0     (w0),
        .w1     (w1),
        .w2     (w2),
        .w3     (w3),
        .w4     (w4),
        .w5     (w5),
        .w6     (w6),
        .w7     (w7)
    );

endmodule
